// File: rtl/vga_timing_generator.sv
// rtl/vga_timing_generator.sv - VGA raster timing generator with nested pixel/line counters
// Status outputs are registered from next-state counts so they align with the counts they describe.
module vga_timing_generator #(
  parameter int   COUNTER_SIZE = 11,
  parameter int   H_VISIBLE    = 1024,
  parameter int   H_FRONT      = 24,
  parameter int   H_SYNC       = 136,
  parameter int   H_BACK       = 160,
  parameter int   V_VISIBLE    = 768,
  parameter int   V_FRONT      = 3,
  parameter int   V_SYNC       = 6,
  parameter int   V_BACK       = 29,
  parameter logic H_SYNC_POL   = 1'b0,
  parameter logic V_SYNC_POL   = 1'b0
) (
  input  logic                    control_clock,
  input  logic                    reset,
  input  logic                    pixel_enable,
  output logic [COUNTER_SIZE-1:0] h_count,
  output logic [COUNTER_SIZE-1:0] v_count,
  output logic                    h_sync,
  output logic                    v_sync,
  output logic                    display_active,
  output logic                    line_start,
  output logic                    frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [COUNTER_SIZE-1:0] H_LAST       = COUNTER_SIZE'(H_TOTAL - 1);
  localparam logic [COUNTER_SIZE-1:0] V_LAST       = COUNTER_SIZE'(V_TOTAL - 1);
  localparam logic [COUNTER_SIZE-1:0] H_VIS        = COUNTER_SIZE'(H_VISIBLE);
  localparam logic [COUNTER_SIZE-1:0] V_VIS        = COUNTER_SIZE'(V_VISIBLE);
  localparam logic [COUNTER_SIZE-1:0] H_SYNC_FIRST = COUNTER_SIZE'(H_VISIBLE + H_FRONT);
  localparam logic [COUNTER_SIZE-1:0] H_SYNC_LAST  = COUNTER_SIZE'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [COUNTER_SIZE-1:0] V_SYNC_FIRST = COUNTER_SIZE'(V_VISIBLE + V_FRONT);
  localparam logic [COUNTER_SIZE-1:0] V_SYNC_LAST  = COUNTER_SIZE'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [COUNTER_SIZE-1:0] h_count_q, h_count_d;
  logic [COUNTER_SIZE-1:0] v_count_q, v_count_d;
  logic h_sync_q, h_sync_d;
  logic v_sync_q, v_sync_d;
  logic active_q, active_d;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;
  logic h_wrap, v_wrap;

  always_comb begin
    // Using >= rather than == also pulls any out-of-range count back to 0.
    h_wrap        = (h_count_q >= H_LAST);
    v_wrap        = (v_count_q >= V_LAST);
    h_count_d     = h_count_q;
    v_count_d     = v_count_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    if (pixel_enable) begin
      h_count_d = h_wrap ? '0 : h_count_q + 1'b1;
      if (v_count_q > V_LAST) begin
        v_count_d = '0;
      end else if (h_wrap) begin
        v_count_d = v_wrap ? '0 : v_count_q + 1'b1;
      end
      line_start_d  = h_wrap;
      frame_start_d = h_wrap && v_wrap;
    end
    h_sync_d = ((h_count_d >= H_SYNC_FIRST) && (h_count_d <= H_SYNC_LAST)) ? H_SYNC_POL : ~H_SYNC_POL;
    v_sync_d = ((v_count_d >= V_SYNC_FIRST) && (v_count_d <= V_SYNC_LAST)) ? V_SYNC_POL : ~V_SYNC_POL;
    active_d = (h_count_d < H_VIS) && (v_count_d < V_VIS);
  end

  always_ff @(posedge control_clock) begin
    if (reset) begin
      h_count_q     <= '0;
      v_count_q     <= '0;
      h_sync_q      <= ~H_SYNC_POL;
      v_sync_q      <= ~V_SYNC_POL;
      active_q      <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_count_q     <= h_count_d;
      v_count_q     <= v_count_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      active_q      <= active_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign h_count        = h_count_q;
  assign v_count        = v_count_q;
  assign h_sync         = h_sync_q;
  assign v_sync         = v_sync_q;
  assign display_active = active_q;
  assign line_start     = line_start_q;
  assign frame_start    = frame_start_q;

endmodule

// File: tb/tb_vga_timing_generator.sv
// tb/tb_vga_timing_generator.sv - bench for vga_timing_generator on an 8x6 raster
// Two instances share stimulus: active-low syncs (dut) and active-high syncs (dut_p).
module tb_vga_timing_generator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [3:0] h_count, v_count, h_count_p, v_count_p;
  logic       h_sync, v_sync, active, ls, fs;
  logic       h_sync_p, v_sync_p, active_p, ls_p, fs_p;

  always #5 clk = ~clk;

  vga_timing_generator #(
    .COUNTER_SIZE(4), .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0)
  ) dut (
    .control_clock(clk), .reset(rst), .pixel_enable(en),
    .h_count(h_count), .v_count(v_count), .h_sync(h_sync), .v_sync(v_sync),
    .display_active(active), .line_start(ls), .frame_start(fs)
  );

  vga_timing_generator #(
    .COUNTER_SIZE(4), .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1)
  ) dut_p (
    .control_clock(clk), .reset(rst), .pixel_enable(en),
    .h_count(h_count_p), .v_count(v_count_p), .h_sync(h_sync_p), .v_sync(v_sync_p),
    .display_active(active_p), .line_start(ls_p), .frame_start(fs_p)
  );

  typedef struct packed {
    logic [3:0] h;
    logic [3:0] v;
    logic       hs;
    logic       vs;
    logic       da;
    logic       ls;
    logic       fs;
  } out_t;

  typedef struct {
    bit rst;
    bit en;
    int h;
    int v;
    bit ls;
    bit fs;
  } vec_t;

  out_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   m_h = 0, m_v = 0;
  bit   m_ls = 0, m_fs = 0;
  int   cycle = 0;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cycle);
    end
  endtask

  // Reference raster: 8 pixels/line, 6 lines/frame; sync at h 5..6 and v 4.
  function automatic out_t model_step(input bit r, input bit e);
    out_t o;
    if (r) begin
      m_h = 0; m_v = 0; m_ls = 0; m_fs = 0;
    end else if (e) begin
      m_ls = (m_h == 7);
      m_fs = m_ls && (m_v == 5);
      m_h  = (m_h + 1) % 8;
      if (m_ls) m_v = (m_v + 1) % 6;
    end else begin
      m_ls = 0; m_fs = 0;
    end
    o.h  = 4'(m_h);
    o.v  = 4'(m_v);
    o.hs = !(m_h == 5 || m_h == 6);
    o.vs = !(m_v == 4);
    o.da = (m_h < 4) && (m_v < 3);
    o.ls = m_ls;
    o.fs = m_fs;
    return o;
  endfunction

  task automatic step(input bit r, input bit e);
    out_t exp_o, act_o;
    @(negedge clk);
    rst = r;
    en  = e;
    exp_q.push_back(model_step(r, e));
    @(posedge clk);
    #1;
    cycle++;
    exp_o = exp_q.pop_front();
    act_o = '{h: h_count, v: v_count, hs: h_sync, vs: v_sync, da: active, ls: ls, fs: fs};
    check("outputs_pol0", int'(act_o), int'(exp_o));
    check("syncs_pol1", int'({h_sync_p, v_sync_p}), int'({~exp_o.hs, ~exp_o.vs}));
  endtask

  vec_t vecs[$];
  int   fs_cycles[$];
  int   ls_count, fs_count, hs_low, vs_low, da_high, budget;

  initial begin
    // Enable toggle 1,0,0,1 after reset, then reset mid-line with enable high.
    vecs.push_back('{rst: 1, en: 0, h: 0, v: 0, ls: 0, fs: 0});
    vecs.push_back('{rst: 0, en: 1, h: 1, v: 0, ls: 0, fs: 0});
    vecs.push_back('{rst: 0, en: 0, h: 1, v: 0, ls: 0, fs: 0});
    vecs.push_back('{rst: 0, en: 0, h: 1, v: 0, ls: 0, fs: 0});
    vecs.push_back('{rst: 0, en: 1, h: 2, v: 0, ls: 0, fs: 0});
    vecs.push_back('{rst: 1, en: 1, h: 0, v: 0, ls: 0, fs: 0});
    vecs.push_back('{rst: 0, en: 1, h: 1, v: 0, ls: 0, fs: 0});

    step(1'b1, 1'b0);
    check("reset_h_sync_pol0", int'(h_sync), 1);
    check("reset_v_sync_pol0", int'(v_sync), 1);
    check("reset_h_sync_pol1", int'(h_sync_p), 0);
    check("reset_v_sync_pol1", int'(v_sync_p), 0);
    check("reset_display_active", int'(active), 1);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].en);
      check($sformatf("vec%0d_h", i), int'(h_count), vecs[i].h);
      check($sformatf("vec%0d_v", i), int'(v_count), vecs[i].v);
      check($sformatf("vec%0d_strobes", i), int'({ls, fs}), int'({vecs[i].ls, vecs[i].fs}));
    end

    // Fresh start, then two full frames with enable held high.
    step(1'b1, 1'b0);
    ls_count = 0; fs_count = 0; hs_low = 0; vs_low = 0; da_high = 0;
    for (int c = 0; c < 96; c++) begin
      step(1'b0, 1'b1);
      if (ls) ls_count++;
      if (fs) begin
        fs_count++;
        fs_cycles.push_back(c);
        check("frame_start_pos", int'({h_count, v_count}), 0);
      end
      if (ls) check("line_start_h", int'(h_count), 0);
      if (!h_sync) hs_low++;
      if (!v_sync) vs_low++;
      if (active) da_high++;
    end
    check("line_start_count", ls_count, 12);
    check("frame_start_count", fs_count, 2);
    check("h_sync_low_cycles", hs_low, 24);
    check("v_sync_low_cycles", vs_low, 16);
    check("display_active_cycles", da_high, 24);
    if (fs_cycles.size() == 2) check("frame_start_spacing", fs_cycles[1] - fs_cycles[0], 48);
    else check("frame_start_samples", fs_cycles.size(), 2);

    // Run to (6,4) and reset with enable high.
    budget = 0;
    while (!(m_h == 6 && m_v == 4) && budget < 100) begin
      step(1'b0, 1'b1);
      budget++;
    end
    check("reach_6_4", int'({h_count, v_count}), int'({4'd6, 4'd4}));
    step(1'b1, 1'b1);
    check("midreset_counts", int'({h_count, v_count}), 0);
    check("midreset_syncs", int'({h_sync, v_sync, h_sync_p, v_sync_p}), int'(4'b1100));
    check("midreset_status", int'({active, ls, fs}), int'(3'b100));
    for (int c = 0; c < 10; c++) step(1'b0, 1'b1);
    check("resume_h", int'(h_count), 2);
    check("resume_v", int'(v_count), 1);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/vga_timing_generator.md
Name: vga_timing_generator

Overview:
- Parametrised successor to the single free-running frame counter: a two-dimensional VGA raster timing generator.
- Nested horizontal (pixel) and vertical (line) counters, with front porch, sync and back porch widths set per axis. Produces registered h/v sync with selectable polarity, display-active, and line/frame start strobes.
- Sits between the pixel-clock source and the pixel/colour pipeline. Advances only on a pixel-enable tick, so the system clock may run faster than the pixel rate.

Parameters:
- COUNTER_SIZE, 11, width of h_count and v_count; must hold H_TOTAL-1 and V_TOTAL-1.
- H_VISIBLE, 1024, visible pixels per line.
- H_FRONT, 24, horizontal front porch in pixels.
- H_SYNC, 136, horizontal sync width in pixels.
- H_BACK, 160, horizontal back porch in pixels.
- V_VISIBLE, 768, visible lines per frame.
- V_FRONT, 3, vertical front porch in lines.
- V_SYNC, 6, vertical sync width in lines.
- V_BACK, 29, vertical back porch in lines.
- H_SYNC_POL, 0, active level of h_sync (0 = active-low).
- V_SYNC_POL, 0, active level of v_sync (0 = active-low).
- Derived: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (1344); V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (806). All porch/sync parameters are >= 1.

Ports:
- control_clock  input  1  system clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- pixel_enable  input  1  advance tick; tie to 1 when control_clock is the pixel clock.
- h_count  output  COUNTER_SIZE  current pixel column, 0..H_TOTAL-1.
- v_count  output  COUNTER_SIZE  current line, 0..V_TOTAL-1.
- h_sync  output  1  horizontal sync, registered.
- v_sync  output  1  vertical sync, registered.
- display_active  output  1  high when h_count < H_VISIBLE and v_count < V_VISIBLE.
- line_start  output  1  one-cycle strobe on entering h_count = 0.
- frame_start  output  1  one-cycle strobe on entering (h_count, v_count) = (0, 0).

Behaviour:
- Single clock domain, single synchronous, active-high reset (reset). No asynchronous paths.
- Reset, checked with priority over pixel_enable:
  - h_count = 0, v_count = 0.
  - h_sync = ~H_SYNC_POL, v_sync = ~V_SYNC_POL.
  - display_active = 1.
  - line_start = 0, frame_start = 0.
- pixel_enable = 0: counters, h_sync, v_sync and display_active hold. line_start and frame_start are 0.
- pixel_enable = 1 advance:
  - h_count increments by 1. At H_TOTAL-1 it wraps to 0 and v_count advances.
  - v_count increments only on h wrap. At V_TOTAL-1 (together with the h wrap) it wraps to 0.
  - No count value is ever >= H_TOTAL or V_TOTAL. Any out-of-range value is forced to 0 on the next advance.
- Status outputs are all registered. They are computed from the next count values, so on every cycle they describe the h_count/v_count presented on that same cycle (zero relative latency):
  - h_sync = H_SYNC_POL when H_VISIBLE+H_FRONT <= h_count <= H_VISIBLE+H_FRONT+H_SYNC-1 (1048..1183 at defaults); otherwise ~H_SYNC_POL.
  - v_sync = V_SYNC_POL when V_VISIBLE+V_FRONT <= v_count <= V_VISIBLE+V_FRONT+V_SYNC-1 (771..776); otherwise ~V_SYNC_POL. v_sync changes only in the same cycle h_count becomes 0.
  - display_active is as defined in Ports.
- Strobes:
  - line_start = 1 for exactly one cycle when an advance moves h_count from H_TOTAL-1 to 0.
  - frame_start = 1 additionally when that same advance also moves v_count from V_TOTAL-1 to 0.
  - Neither strobe is asserted by reset itself.
- Reset mid-frame: the next cycle shows the reset values and counting restarts from (0,0). No strobe is issued.
- Reset and pixel_enable high in the same cycle: reset wins; counts are 0 afterwards, not 1.
- Frame period: H_TOTAL*V_TOTAL advances (1,083,264 at defaults).

Test Plan:
- Reset then pixel_enable held at 1 with small parameters (H 4/1/2/1, V 3/1/1/1, COUNTER_SIZE 4): h_count sequence 0..7,0; v_count steps 0..5, wraps 5->0 after 48 advances; frame_start pulses exactly once per 48 cycles, line_start once per 8 cycles.
- Same parameters, polarity 0: h_sync low only at h_count 5,6; v_sync low only at v_count 4; display_active high only for h<4 and v<3 (12 of 48 cycles).
- Polarity 1 on both axes: h_sync/v_sync waveforms exactly inverted versus the previous scenario; reset value of h_sync and v_sync is 0.
- pixel_enable toggling 1,0,0,1 from reset: h_count 0→1, held at 1 for two cycles, then 2; strobes never asserted while enable is low.
- Reset asserted at (h=6, v=4) with pixel_enable=1: next cycle h=0, v=0, syncs inactive, display_active=1, no strobe; counting resumes normally.
- Default parameters, 2 full frames: h_sync active 136 cycles per line starting at h=1048; v_sync active for 6 lines starting at v=771; frame_start spacing 1,083,264 cycles.
